// File: rtl/multi_bounce_detector_if.sv
// Event stream from the bounce characteriser: one measurement per valid/ready handshake.
interface multi_bounce_detector_if #(
    parameter int CH_BITS      = 2,
    parameter int COUNTER_BITS = 17,
    parameter int EDGE_BITS    = 8
);
    logic                    out_valid;
    logic                    out_ready;
    logic [CH_BITS-1:0]      out_channel;
    logic [COUNTER_BITS-1:0] out_cycles;
    logic [EDGE_BITS-1:0]    out_edges;
    logic                    out_level;

    modport master (
        output out_valid, out_channel, out_cycles, out_edges, out_level,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_channel, out_cycles, out_edges, out_level,
        output out_ready
    );
endinterface

// File: rtl/multi_bounce_detector.sv
// Multi-channel switch-bounce characteriser: per channel, measures first-to-last edge span inside a
// fixed window and streams each result out through a round-robin arbitrated valid/ready stage.
module multi_bounce_detector #(
    parameter longint CLOCK_HZ      = 64'd12_000_000,
    parameter int     INPUT_RATE_HZ = 100,
    parameter int     NUM_CHANNELS  = 4,
    parameter int     SYNC_DEPTH    = 2,
    parameter int     EDGE_BITS     = 8,
    localparam int    WINDOW_CYCLES = int'(CLOCK_HZ / INPUT_RATE_HZ),
    localparam int    COUNTER_BITS  = $clog2(WINDOW_CYCLES),
    localparam int    CH_BITS       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [NUM_CHANNELS-1:0]                async_in,
    input  logic                                   clear_stats,
    multi_bounce_detector_if.master                ev,
    output logic [NUM_CHANNELS*COUNTER_BITS-1:0]   max_cycles,
    output logic [NUM_CHANNELS-1:0]                overflow
);
    typedef enum logic {IDLE, MEAS} state_e;

    logic [NUM_CHANNELS-1:0][SYNC_DEPTH-1:0] sync_q;
    logic [NUM_CHANNELS-1:0]                 s, s_prev_q;
    logic [NUM_CHANNELS-1:0]                 stable_q, stable_d;
    state_e                                  state_q [NUM_CHANNELS];
    state_e                                  state_d [NUM_CHANNELS];
    logic [COUNTER_BITS-1:0]                 cnt_q [NUM_CHANNELS], cnt_d [NUM_CHANNELS];
    logic [COUNTER_BITS-1:0]                 last_q [NUM_CHANNELS], last_d [NUM_CHANNELS];
    logic [EDGE_BITS-1:0]                    edges_q [NUM_CHANNELS], edges_d [NUM_CHANNELS];
    logic [COUNTER_BITS-1:0]                 res_cycles_q [NUM_CHANNELS], res_cycles_d [NUM_CHANNELS];
    logic [EDGE_BITS-1:0]                    res_edges_q [NUM_CHANNELS], res_edges_d [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]                 res_level_q, res_level_d;
    logic [NUM_CHANNELS-1:0]                 pending_q, pending_d;
    logic [NUM_CHANNELS-1:0]                 overflow_q, overflow_d;
    logic [NUM_CHANNELS*COUNTER_BITS-1:0]    max_q, max_d;
    logic [CH_BITS-1:0]                      rr_q, rr_d;
    logic                                    out_valid_q, out_valid_d;
    logic [CH_BITS-1:0]                      out_channel_q, out_channel_d;
    logic [COUNTER_BITS-1:0]                 out_cycles_q, out_cycles_d;
    logic [EDGE_BITS-1:0]                    out_edges_q, out_edges_d;
    logic                                    out_level_q, out_level_d;

    logic                    take, found;
    logic [CH_BITS-1:0]      pick;
    logic [COUNTER_BITS-1:0] last_v, max_base;
    logic [EDGE_BITS-1:0]    edges_v;

    always_comb begin
        for (int i = 0; i < NUM_CHANNELS; i++) s[i] = sync_q[i][SYNC_DEPTH-1];
    end

    // NOTE: every next-state signal takes its hold value first, so no path through this block
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        edges_d       = edges_q;
        stable_d      = stable_q;
        res_cycles_d  = res_cycles_q;
        res_edges_d   = res_edges_q;
        res_level_d   = res_level_q;
        pending_d     = pending_q;
        overflow_d    = overflow_q;
        max_d         = max_q;
        rr_d          = rr_q;
        out_valid_d   = out_valid_q;
        out_channel_d = out_channel_q;
        out_cycles_d  = out_cycles_q;
        out_edges_d   = out_edges_q;
        out_level_d   = out_level_q;
        last_v        = '0;
        edges_v       = '0;
        max_base      = '0;

        // Round-robin: first pending channel at or after the pointer, wrapping.
        take  = (!out_valid_q || ev.out_ready) && (|pending_q);
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            if (!found && pending_q[(int'(rr_q) + k) % NUM_CHANNELS]) begin
                found = 1'b1;
                pick  = CH_BITS'((int'(rr_q) + k) % NUM_CHANNELS);
            end
        end

        if (take) begin
            out_valid_d     = 1'b1;
            out_channel_d   = pick;
            out_cycles_d    = res_cycles_q[pick];
            out_edges_d     = res_edges_q[pick];
            out_level_d     = res_level_q[pick];
            pending_d[pick] = 1'b0;
            rr_d = (int'(pick) == NUM_CHANNELS - 1) ? '0 : CH_BITS'(int'(pick) + 1);
        end else if (ev.out_ready) begin
            out_valid_d = 1'b0;
        end

        if (clear_stats) begin
            overflow_d = '0;
            max_d      = '0;
        end

        for (int i = 0; i < NUM_CHANNELS; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (s[i] != stable_q[i]) begin
                        state_d[i] = MEAS;
                        cnt_d[i]   = '0;
                        last_d[i]  = '0;
                        edges_d[i] = EDGE_BITS'(1);
                    end
                end
                MEAS: begin
                    last_v  = last_q[i];
                    edges_v = edges_q[i];
                    if (s[i] != s_prev_q[i]) begin
                        last_v = cnt_q[i];
                        if (edges_q[i] != '1) edges_v = edges_q[i] + EDGE_BITS'(1);
                    end
                    cnt_d[i]   = cnt_q[i] + COUNTER_BITS'(1);
                    last_d[i]  = last_v;
                    edges_d[i] = edges_v;
                    // Window end: results include an edge seen in this very cycle.
                    if (cnt_q[i] == COUNTER_BITS'(WINDOW_CYCLES - 1)) begin
                        state_d[i]      = IDLE;
                        cnt_d[i]        = '0;
                        stable_d[i]     = s[i];
                        res_cycles_d[i] = last_v;
                        res_edges_d[i]  = edges_v;
                        res_level_d[i]  = s[i];
                        if (pending_q[i] && !(take && int'(pick) == i)) overflow_d[i] = 1'b1;
                        pending_d[i]    = 1'b1;
                        max_base        = max_d[i*COUNTER_BITS +: COUNTER_BITS];
                        if (last_v > max_base) max_d[i*COUNTER_BITS +: COUNTER_BITS] = last_v;
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q        <= '0;
            s_prev_q      <= '0;
            stable_q      <= '0;
            res_level_q   <= '0;
            pending_q     <= '0;
            overflow_q    <= '0;
            max_q         <= '0;
            rr_q          <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            out_cycles_q  <= '0;
            out_edges_q   <= '0;
            out_level_q   <= 1'b0;
            // NOTE: the per-channel result registers are reset too; a consumer may see them
            // through the arbiter and they are small, so no X ever leaves the block.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                state_q[i]      <= IDLE;
                cnt_q[i]        <= '0;
                last_q[i]       <= '0;
                edges_q[i]      <= '0;
                res_cycles_q[i] <= '0;
                res_edges_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CHANNELS; i++)
                sync_q[i] <= {sync_q[i][SYNC_DEPTH-2:0], async_in[i]};
            s_prev_q      <= s;
            stable_q      <= stable_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            edges_q       <= edges_d;
            res_cycles_q  <= res_cycles_d;
            res_edges_q   <= res_edges_d;
            res_level_q   <= res_level_d;
            pending_q     <= pending_d;
            overflow_q    <= overflow_d;
            max_q         <= max_d;
            rr_q          <= rr_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            out_cycles_q  <= out_cycles_d;
            out_edges_q   <= out_edges_d;
            out_level_q   <= out_level_d;
        end
    end

    assign ev.out_valid   = out_valid_q;
    assign ev.out_channel = out_channel_q;
    assign ev.out_cycles  = out_cycles_q;
    assign ev.out_edges   = out_edges_q;
    assign ev.out_level   = out_level_q;
    assign max_cycles     = max_q;
    assign overflow       = overflow_q;
endmodule

// File: tb/tb_multi_bounce_detector.sv
// Directed bench for multi_bounce_detector: table of single-window scenarios plus hand-written
// sequences for simultaneous events, back-pressure overflow, stats clear and mid-window reset.
module tb_multi_bounce_detector;
    localparam int N   = 4;
    localparam int CB  = 4;
    localparam int CHB = 2;
    localparam int EB  = 8;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [N-1:0]  async_in;
    logic          clear_stats;
    logic [N*CB-1:0] max_cycles;
    logic [N-1:0]  overflow;

    int n_vec = 0;
    int n_bad = 0;

    multi_bounce_detector_if #(.CH_BITS(CHB), .COUNTER_BITS(CB), .EDGE_BITS(EB)) ev ();

    multi_bounce_detector #(
        .CLOCK_HZ(64'd1000), .INPUT_RATE_HZ(100), .NUM_CHANNELS(N), .SYNC_DEPTH(2), .EDGE_BITS(EB)
    ) dut (
        .clock(clock), .reset_n(reset_n), .async_in(async_in), .clear_stats(clear_stats),
        .ev(ev), .max_cycles(max_cycles), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // One window scenario: toggles[k] flips the channel so the edge lands at window counter k.
    typedef struct {
        int         ch;
        logic [9:0] toggles;
        logic [3:0] cyc;
        logic [7:0] edg;
        logic       lvl;
        logic [15:0] maxv;
    } vec_t;

    vec_t vecs [5];

    logic [CHB-1:0] g_ch  [8];
    logic [CB-1:0]  g_cyc [8];
    logic [EB-1:0]  g_edg [8];
    logic           g_lvl [8];
    int             g_n;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic sample();
        if (ev.out_valid && ev.out_ready && g_n < 8) begin
            g_ch[g_n]  = ev.out_channel;
            g_cyc[g_n] = ev.out_cycles;
            g_edg[g_n] = ev.out_edges;
            g_lvl[g_n] = ev.out_level;
            g_n++;
        end
    endtask

    task automatic collect(input int budget);
        g_n = 0;
        for (int c = 0; c < budget; c++) begin
            sample();
            tick();
        end
    endtask

    task automatic check_ev(input string name, input int idx, input logic [CHB-1:0] ch,
                            input logic [CB-1:0] cyc, input logic [EB-1:0] edg, input logic lvl);
        check({name, ".ch"},     g_ch[idx],  ch);
        check({name, ".cycles"}, g_cyc[idx], cyc);
        check({name, ".edges"},  g_edg[idx], edg);
        check({name, ".level"},  g_lvl[idx], lvl);
    endtask

    // Counter-0 edge is sampled at edge 1; an edge at counter k>0 must be sampled at edge k+2.
    function automatic int tog_edge(input int k);
        return (k == 0) ? 1 : k + 2;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int first_edge;
        first_edge = 0;
        g_n = 0;
        for (int e = 1; e <= 24; e++) begin
            for (int k = 0; k < 10; k++)
                if (v.toggles[k] && tog_edge(k) == e) async_in[v.ch] = ~async_in[v.ch];
            tick();
            if (ev.out_valid && first_edge == 0) first_edge = e;
            sample();
        end
        check($sformatf("v%0d.latency", idx), first_edge, 14);
        check($sformatf("v%0d.count", idx), g_n, 1);
        check_ev($sformatf("v%0d", idx), 0, CHB'(v.ch), v.cyc, v.edg, v.lvl);
        check($sformatf("v%0d.max", idx), max_cycles, v.maxv);
        check($sformatf("v%0d.ovf", idx), overflow, 0);
    endtask

    initial begin
        logic held_ok;
        int   n_seen;

        vecs[0] = '{ch: 0, toggles: 10'h001, cyc: 4'd0, edg: 8'd1, lvl: 1'b1, maxv: 16'h0000};
        vecs[1] = '{ch: 1, toggles: 10'h025, cyc: 4'd5, edg: 8'd3, lvl: 1'b1, maxv: 16'h0050};
        vecs[2] = '{ch: 1, toggles: 10'h001, cyc: 4'd0, edg: 8'd1, lvl: 1'b0, maxv: 16'h0050};
        vecs[3] = '{ch: 2, toggles: 10'h203, cyc: 4'd9, edg: 8'd3, lvl: 1'b1, maxv: 16'h0950};
        vecs[4] = '{ch: 3, toggles: 10'h009, cyc: 4'd3, edg: 8'd2, lvl: 1'b0, maxv: 16'h3950};

        reset_n      = 1'b0;
        async_in     = '0;
        clear_stats  = 1'b0;
        ev.out_ready = 1'b1;
        #1;
        check("rst.valid", ev.out_valid, 0);
        check("rst.max", max_cycles, 0);
        check("rst.ovf", overflow, 0);
        check("rst.ch", ev.out_channel, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // All four channels step together under back-pressure; pointer is back at ch0.
        ev.out_ready = 1'b0;
        async_in = ~async_in;
        held_ok = 1'b1;
        for (int e = 1; e <= 34; e++) begin
            tick();
            if (e >= 14 && !(ev.out_valid && ev.out_channel == 0 && ev.out_cycles == 0 &&
                             ev.out_edges == 1 && ev.out_level == 0)) held_ok = 1'b0;
        end
        check("sim.held", held_ok, 1);
        ev.out_ready = 1'b1;
        collect(8);
        check("sim.count", g_n, 4);
        for (int i = 0; i < 4; i++)
            check_ev($sformatf("sim%0d", i), i, CHB'(i), 4'd0, 8'd1, i[0]);
        check("sim.ovf", overflow, 0);
        check("sim.max", max_cycles, 16'h3950);
        check("sim.idle", ev.out_valid, 0);

        // Ch0 occupies the output; ch2 completes twice while its first result waits.
        ev.out_ready = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            if (e == 1) async_in[0] = ~async_in[0];
            if (e == 1 || e == 15 || e == 18 || e == 20) async_in[2] = ~async_in[2];
            tick();
        end
        check("ovf.flag", overflow, 4'b0100);
        check("ovf.max", max_cycles, 16'h3950);
        ev.out_ready = 1'b1;
        collect(6);
        check("ovf.count", g_n, 2);
        check_ev("ovf0", 0, 2'd0, 4'd0, 8'd1, 1'b1);
        check_ev("ovf1", 1, 2'd2, 4'd4, 8'd3, 1'b0);
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        check("clr.ovf", overflow, 0);
        check("clr.max", max_cycles, 0);

        // Stalled ch1 event plus ch0 mid-window (counter 4) when reset hits.
        ev.out_ready = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            if (e == 1)  async_in[1] = ~async_in[1];
            if (e == 15) async_in[0] = ~async_in[0];
            tick();
        end
        check("rstmid.pre_valid", ev.out_valid, 1);
        reset_n  = 1'b0;
        async_in = '0;
        #1;
        check("rstmid.valid", ev.out_valid, 0);
        check("rstmid.max", max_cycles, 0);
        ev.out_ready = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        n_seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ev.out_valid) n_seen++;
        end
        check("rstmid.no_event", n_seen, 0);
        check("rstmid.ovf", overflow, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
